reg_cmd_sequencer: RTL
======================

// Module: reg_cmd_sequencer
// PURPOSE
//  Upstream command sequencer for the 3-bit-ctrl counting register. Accepts one
//  op per valid/ready handshake (CLR, LOAD, INCR xN, DECR xN) and drives the
//  register's ctrl/data_input for the required cycles. Reads the register output
//  back as reg_value. Pulses done when the op has been fully issued.
// PARAMETERS
//  DATA_WIDTH  8  width of cmd_data, data_input, reg_value
//  CNT_WIDTH   4  width of cmd_count (repeat count for INCR/DECR)
// PORTS
//  clk        in   1           clock, all state updates on rising edge
//  rst        in   1           reset, asynchronous, active-low
//  cmd_valid  in   1           command offered
//  cmd_ready  out  1           sequencer can accept (combinational: state==IDLE)
//  cmd_op     in   2           0=CLR 1=LOAD 2=INCR 3=DECR
//  cmd_count  in   CNT_WIDTH   repeat count, INCR/DECR only; ignored for CLR/LOAD
//  cmd_data   in   DATA_WIDTH  load value, LOAD only
//  ctrl       out  3           to register: 0=NONE 1=CLR 2=LOAD 3=INCR 4=DECR
//  data_input out  DATA_WIDTH  to register load port (latched cmd_data)
//  reg_value  in   DATA_WIDTH  register data_output feedback
//  busy       out  1           1 in ISSUE or DONE
//  done       out  1           one-cycle pulse, op finished
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, op/count/data latches=0, ctrl=0 (NONE),
//   data_input=0, busy=0, done=0, cmd_ready=1 once rst releases.
//  States IDLE, ISSUE, DONE (2-bit encoded).
//  IDLE: cmd_ready=1, ctrl=NONE. Handshake = cmd_valid&cmd_ready at rising edge:
//   latch op, data, count. CLR/LOAD -> ISSUE with remaining=1. INCR/DECR with
//   cmd_count!=0 -> ISSUE with remaining=cmd_count. INCR/DECR with cmd_count==0
//   -> DONE directly (no ctrl issued). cmd_op/cmd_data ignored without handshake.
//  ISSUE: ctrl combinational = op's code; data_input = latched data throughout.
//   Each edge: remaining-=1; remaining==1 -> DONE. Register changes on the same
//   edge, so after N ISSUE cycles reg_value reflects N steps.
//  DONE: ctrl=NONE, done=1 for exactly one cycle, busy=1, cmd_ready=0 -> IDLE.
//  Latency: handshake edge E0; ctrl active cycles E0..E0+N; done high in cycle
//   after last ISSUE cycle; next command accepted earliest at E0+N+2 edge.
//  Throughput: one op per N+2 cycles (CLR/LOAD: 3 cycles).
//  Arithmetic: remaining is CNT_WIDTH bits, unsigned; max repeat 2^CNT_WIDTH-1.
//   Register wrap (INCR at all-ones -> 0, DECR at 0 -> all-ones) is allowed unless
//   saturation is compiled in.
//  busy = (state!=IDLE); cmd_ready = (state==IDLE); never both 1.
//  Reset mid-op: all state cleared immediately, ctrl=NONE, no done pulse, op lost.
//  cmd_valid held high through busy: command stays pending, accepted in IDLE.
// CONFIGURATION
//  Macro REG_CMD_SATURATE_EN:
//   Defined: in ISSUE, if op=INCR and reg_value=all-ones, or op=DECR and
//    reg_value=0, ctrl=NONE that cycle and state -> DONE (remaining discarded);
//    done pulses normally. Register never wraps via this block.
//   Undefined: reg_value unused; all N steps issued; wrap-around permitted.
// TESTING
//  1 Reset: rst=0 mid-INCR x5 -> ctrl=0, busy=0, done=0, cmd_ready=1 after release.
//  2 LOAD 8'hA5 -> ctrl=2 for 1 cycle, data_input=8'hA5, reg=8'hA5, done 1 cycle
//    later, cmd_ready back 3 cycles after handshake.
//  3 From reg=8'h10, INCR count=5 -> ctrl=3 for exactly 5 cycles, reg=8'h15, then
//    DECR count=15 -> reg=8'h06; count=0 INCR -> no ctrl, done next cycle.
//  4 Reg=8'hFE, INCR count=4: without REG_CMD_SATURATE_EN -> reg=8'h02 (wrap);
//    with it -> 1 INCR, reg=8'hFF, ctrl=NONE, done, remaining dropped.
//  5 cmd_valid held high with back-to-back CLR then LOAD 8'h3C -> second accepted
//    only in IDLE; reg sequence 0 then 8'h3C; cmd_ready never high while busy.

Source files
------------

// File: rtl/reg_cmd_sequencer_if.sv
// Command handshake bundle between an upstream issuer and reg_cmd_sequencer.
// cmd_valid/cmd_op/cmd_count/cmd_data come from the master; cmd_ready comes from the slave.
interface reg_cmd_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [CNT_WIDTH-1:0]  cmd_count;
    logic [DATA_WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_count,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_count,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/reg_cmd_sequencer.sv
// Issues CLR/LOAD/INCRxN/DECRxN ops to the 3-bit-ctrl counting register, one op per handshake.
// Optional macro REG_CMD_SATURATE_EN stops INCR/DECR at the register's all-ones/zero limit.
module reg_cmd_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_cmd_sequencer_if.slave    cmd,
    output logic [2:0]            ctrl_o,
    output logic [DATA_WIDTH-1:0] data_input_o,
    input  logic [DATA_WIDTH-1:0] reg_value_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            state_o
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and cmd_* are ignored on any other edge.

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] OP_CLR  = 2'd0;
    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_INCR = 2'd2;
    localparam logic [1:0] OP_DECR = 2'd3;

    localparam logic [2:0] CTRL_NONE = 3'd0;
    localparam logic [2:0] CTRL_CLR  = 3'd1;
    localparam logic [2:0] CTRL_LOAD = 3'd2;
    localparam logic [2:0] CTRL_INCR = 3'd3;
    localparam logic [2:0] CTRL_DECR = 3'd4;

    logic [1:0]            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [2:0]            op_ctrl;
    logic                  sat_hit;

    always_comb begin
        op_ctrl = CTRL_NONE;
        case (op_q)
            OP_CLR:  op_ctrl = CTRL_CLR;
            OP_LOAD: op_ctrl = CTRL_LOAD;
            OP_INCR: op_ctrl = CTRL_INCR;
            OP_DECR: op_ctrl = CTRL_DECR;
            default: op_ctrl = CTRL_NONE;
        endcase
    end

`ifdef REG_CMD_SATURATE_EN
    // The register would wrap on this step, so the op ends here instead.
    assign sat_hit = ((op_q == OP_INCR) && (reg_value_i == {DATA_WIDTH{1'b1}})) ||
                     ((op_q == OP_DECR) && (reg_value_i == {DATA_WIDTH{1'b0}}));
`else
    logic unused_reg_value;
    assign unused_reg_value = ^reg_value_i;
    assign sat_hit          = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        ctrl_o      = CTRL_NONE;

        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    op_d   = cmd.cmd_op;
                    data_d = cmd.cmd_data;
                    if ((cmd.cmd_op == OP_CLR) || (cmd.cmd_op == OP_LOAD)) begin
                        remaining_d = CNT_WIDTH'(1);
                        state_d     = ST_ISSUE;
                    end else if (cmd.cmd_count != '0) begin
                        remaining_d = cmd.cmd_count;
                        state_d     = ST_ISSUE;
                    end else begin
                        // Zero-length INCR/DECR completes without touching the register.
                        remaining_d = '0;
                        state_d     = ST_DONE;
                    end
                end
            end

            ST_ISSUE: begin
                ctrl_o      = op_ctrl;
                remaining_d = remaining_q - CNT_WIDTH'(1);
                if (remaining_q == CNT_WIDTH'(1)) begin
                    state_d = ST_DONE;
                end
                if (sat_hit) begin
                    ctrl_o      = CTRL_NONE;
                    remaining_d = '0;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_CLR;
            remaining_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
        end
    end

    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
    assign data_input_o  = data_q;
    assign state_o       = state_q;

endmodule
